// File: rtl/l23_pkt_buffer_pkg.sv
// Shared types and constants for the L2/L3 store-and-forward packet buffer.
package l23_pkt_buffer_pkg;

    // Write-side frame state: storing beats, or discarding the rest of an overflowed frame
    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_t;

    // Storage entry layout is {tlast, tdata}: tlast sits one bit above the data field
    localparam int unsigned ENTRY_LAST_EXTRA = 1;

    // Width of one storage entry for a given tdata width
    function automatic int unsigned entry_w(input int unsigned data_w);
        return data_w + ENTRY_LAST_EXTRA;
    endfunction

endpackage

// File: rtl/l23_pkt_buffer_sdpram.sv
// Simple dual-port RAM: synchronous write port, asynchronous read port.
module l23_pkt_buffer_sdpram #(
    parameter int W  = 9,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    // Store one entry per accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/l23_pkt_buffer.sv
// Store-and-forward AXI-Stream packet FIFO: forwards only complete good frames,
// discards bad and overflowing frames, and keeps saturating frame counters.
module l23_pkt_buffer
    import l23_pkt_buffer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    parameter int STALL  = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] L23i_tdata,
    input  logic              L23i_tlast,
    input  logic              L23i_tuser,
    output logic              L23i_tready,
    input  logic              L23i_tvalid,
    output logic [DATA_W-1:0] L23o_tdata,
    output logic              L23o_tlast,
    input  logic              L23o_tready,
    output logic              L23o_tvalid,
    output logic [CNT_W-1:0]  stat_ok,
    output logic [CNT_W-1:0]  stat_drop
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int PW    = ADDR_W + 1;
    localparam int EW    = entry_w(DATA_W);

    wr_state_t        state_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    commit_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] ok_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;

    logic [PW-1:0]    fill_s;
    logic             full_s;
    logic             no_committed_s;
    logic             in_ready_s;
    logic             in_fire_s;
    logic             out_valid_s;
    logic             out_fire_s;
    logic             we_s;
    logic [EW-1:0]    rd_entry_s;

    // Counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    assign fill_s         = wr_ptr_r - rd_ptr_r;
    assign full_s         = (fill_s == PW'(DEPTH));
    assign no_committed_s = (rd_ptr_r == commit_ptr_r);

    // Input ready: only the stalling variant in ACCEPT may push back, and never when the
    // open frame alone fills the buffer (that frame can only be dropped)
    always_comb begin
        in_ready_s = 1'b1;
        if (state_r == DROP) begin
            in_ready_s = 1'b1;
        end else if (STALL == 0) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = !full_s || no_committed_s;
        end
    end

    assign in_fire_s   = L23i_tvalid && in_ready_s;
    assign out_valid_s = !no_committed_s;
    assign out_fire_s  = out_valid_s && L23o_tready;
    assign we_s        = in_fire_s && (state_r == ACCEPT) && !full_s;

    l23_pkt_buffer_sdpram #(
        .W  (EW),
        .AW (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata ({L23i_tlast, L23i_tdata}),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (rd_entry_s)
    );

    // Pointer, frame-state and statistics update; full/commit decisions use pre-edge pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ACCEPT;
            wr_ptr_r     <= {PW{1'b0}};
            commit_ptr_r <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            ok_cnt_r     <= {CNT_W{1'b0}};
            drop_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (out_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (in_fire_s) begin
                case (state_r)
                    ACCEPT: begin
                        if (full_s) begin
                            if (L23i_tlast) begin
                                wr_ptr_r   <= commit_ptr_r;
                                drop_cnt_r <= sat_inc(drop_cnt_r);
                            end else begin
                                state_r <= DROP;
                            end
                        end else if (L23i_tlast && !L23i_tuser) begin
                            wr_ptr_r     <= wr_ptr_r + PW'(1);
                            commit_ptr_r <= wr_ptr_r + PW'(1);
                            ok_cnt_r     <= sat_inc(ok_cnt_r);
                        end else if (L23i_tlast) begin
                            wr_ptr_r   <= commit_ptr_r;
                            drop_cnt_r <= sat_inc(drop_cnt_r);
                        end else begin
                            wr_ptr_r <= wr_ptr_r + PW'(1);
                        end
                    end
                    DROP: begin
                        if (L23i_tlast) begin
                            wr_ptr_r   <= commit_ptr_r;
                            drop_cnt_r <= sat_inc(drop_cnt_r);
                            state_r    <= ACCEPT;
                        end else begin
                            state_r <= DROP;
                        end
                    end
                    default: begin
                        state_r <= ACCEPT;
                    end
                endcase
            end
        end
    end

    assign L23i_tready = in_ready_s;
    assign L23o_tvalid = out_valid_s;
    assign L23o_tdata  = rd_entry_s[DATA_W-1:0];
    assign L23o_tlast  = rd_entry_s[DATA_W];
    assign stat_ok     = ok_cnt_r;
    assign stat_drop   = drop_cnt_r;

endmodule

// File: tb/tb_l23_pkt_buffer.sv
// Directed bench for l23_pkt_buffer: three instances cover the default buffer,
// a small non-stalling buffer and a small stalling buffer.
module tb_l23_pkt_buffer;

    logic clk = 1'b0;
    logic rst;

    logic [7:0]  i_data  [3];
    logic        i_last  [3];
    logic        i_user  [3];
    logic        i_valid [3];
    logic        i_ready [3];
    logic [7:0]  o_data  [3];
    logic        o_last  [3];
    logic        o_valid [3];
    logic        o_ready [3];
    logic [15:0] st_ok   [3];
    logic [15:0] st_drop [3];

    int total = 0;
    int bad   = 0;
    int vcnt1 = 0;
    bit done5;

    logic [8:0] q0  [$];
    logic [8:0] q1  [$];
    logic [8:0] q2  [$];
    logic [8:0] exq [$];

    always #5 clk = ~clk;

    l23_pkt_buffer #(.DATA_W(8), .ADDR_W(9), .STALL(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .L23i_tdata(i_data[0]), .L23i_tlast(i_last[0]), .L23i_tuser(i_user[0]),
        .L23i_tready(i_ready[0]), .L23i_tvalid(i_valid[0]),
        .L23o_tdata(o_data[0]), .L23o_tlast(o_last[0]), .L23o_tready(o_ready[0]),
        .L23o_tvalid(o_valid[0]), .stat_ok(st_ok[0]), .stat_drop(st_drop[0]));

    l23_pkt_buffer #(.DATA_W(8), .ADDR_W(3), .STALL(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst),
        .L23i_tdata(i_data[1]), .L23i_tlast(i_last[1]), .L23i_tuser(i_user[1]),
        .L23i_tready(i_ready[1]), .L23i_tvalid(i_valid[1]),
        .L23o_tdata(o_data[1]), .L23o_tlast(o_last[1]), .L23o_tready(o_ready[1]),
        .L23o_tvalid(o_valid[1]), .stat_ok(st_ok[1]), .stat_drop(st_drop[1]));

    l23_pkt_buffer #(.DATA_W(8), .ADDR_W(3), .STALL(1), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst),
        .L23i_tdata(i_data[2]), .L23i_tlast(i_last[2]), .L23i_tuser(i_user[2]),
        .L23i_tready(i_ready[2]), .L23i_tvalid(i_valid[2]),
        .L23o_tdata(o_data[2]), .L23o_tlast(o_last[2]), .L23o_tready(o_ready[2]),
        .L23o_tvalid(o_valid[2]), .stat_ok(st_ok[2]), .stat_drop(st_drop[2]));

    // Record each output beat whose handshake completes at the next rising edge
    always @(negedge clk) begin
        if (o_valid[0] && o_ready[0]) q0.push_back({o_last[0], o_data[0]});
        if (o_valid[1] && o_ready[1]) q1.push_back({o_last[1], o_data[1]});
        if (o_valid[2] && o_ready[2]) q2.push_back({o_last[2], o_data[2]});
        if (o_valid[1]) vcnt1 = vcnt1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int sel, input logic [7:0] d, input logic l,
                             input logic u, input bit gaps);
        int n;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            @(posedge clk);
            #1;
        end
        i_data[sel]  = d;
        i_last[sel]  = l;
        i_user[sel]  = u;
        i_valid[sel] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (i_ready[sel]) break;
            n++;
            if (n > 200) begin
                chk("in_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        i_valid[sel] = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int base, input int n,
                              input bit badf, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_beat(sel, 8'(base + i), (i == n - 1), badf && (i == n - 1), gaps);
        end
    endtask

    task automatic add_exp(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            exq.push_back({(i == n - 1) ? 1'b1 : 1'b0, 8'(base + i)});
        end
    endtask

    task automatic expect_q(input int sel, input int start, input string tag);
        logic [8:0] q [$];
        case (sel)
            0:       q = q0;
            1:       q = q1;
            default: q = q2;
        endcase
        chk({tag, "_cnt"}, 32'(q.size() - start), 32'(exq.size()));
        for (int i = 0; i < exq.size(); i++) begin
            if (start + i < q.size()) chk(tag, 32'(q[start + i]), 32'(exq[i]));
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < 3; k++) i_valid[k] = 1'b0;
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        for (int k = 0; k < 3; k++) begin
            i_data[k]  = 8'd0;
            i_last[k]  = 1'b0;
            i_user[k]  = 1'b0;
            i_valid[k] = 1'b0;
            o_ready[k] = 1'b0;
        end
        rst = 1'b0;
        #3;
        chk("rst_ovalid", 32'(o_valid[0]), 32'd0);
        chk("rst_iready", 32'(i_ready[0]), 32'd1);
        chk("rst_iready_stall", 32'(i_ready[2]), 32'd1);
        chk("rst_ok", 32'(st_ok[0]), 32'd0);
        chk("rst_drop", 32'(st_drop[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Good 7-beat frame, first out-valid right after the tlast edge
        o_ready[0] = 1'b1;
        start = q0.size();
        for (int i = 0; i < 6; i++) send_beat(0, 8'(11 + i), 1'b0, 1'b0, 1'b0);
        chk("t1_pre_valid", 32'(o_valid[0]), 32'd0);
        send_beat(0, 8'd17, 1'b1, 1'b0, 1'b0);
        chk("t1_latency", 32'(o_valid[0]), 32'd1);
        wait_cycles(12);
        exq.delete(); add_exp(11, 7);
        expect_q(0, start, "t1_data");
        chk("t1_ok", 32'(st_ok[0]), 32'd1);
        chk("t1_drop", 32'(st_drop[0]), 32'd0);

        // Bad frame followed by a good one
        do_reset();
        o_ready[0] = 1'b1;
        start = q0.size();
        send_frame(0, 31, 7, 1'b1, 1'b0);
        send_frame(0, 41, 9, 1'b0, 1'b0);
        wait_cycles(15);
        exq.delete(); add_exp(41, 9);
        expect_q(0, start, "t2_data");
        chk("t2_ok", 32'(st_ok[0]), 32'd1);
        chk("t2_drop", 32'(st_drop[0]), 32'd1);

        // Small non-stalling buffer: oversize frame is dropped, next frame passes
        start = vcnt1;
        send_frame(1, 1, 10, 1'b0, 1'b0);
        wait_cycles(3);
        chk("t3_no_valid", 32'(vcnt1 - start), 32'd0);
        chk("t3_drop", 32'(st_drop[1]), 32'd1);
        chk("t3_ok0", 32'(st_ok[1]), 32'd0);
        chk("t3_iready", 32'(i_ready[1]), 32'd1);
        o_ready[1] = 1'b1;
        start = q1.size();
        send_frame(1, 101, 4, 1'b0, 1'b0);
        wait_cycles(10);
        exq.delete(); add_exp(101, 4);
        expect_q(1, start, "t3_data");
        chk("t3_ok1", 32'(st_ok[1]), 32'd1);

        // Small stalling buffer: backpressure once full, nothing lost
        start = q2.size();
        send_frame(2, 1, 6, 1'b0, 1'b0);
        send_beat(2, 8'd7, 1'b0, 1'b0, 1'b0);
        send_beat(2, 8'd8, 1'b0, 1'b0, 1'b0);
        chk("t4_stall", 32'(i_ready[2]), 32'd0);
        wait_cycles(3);
        chk("t4_hold", 32'(i_ready[2]), 32'd0);
        o_ready[2] = 1'b1;
        send_beat(2, 8'd9, 1'b0, 1'b0, 1'b0);
        send_beat(2, 8'd10, 1'b0, 1'b0, 1'b0);
        send_beat(2, 8'd11, 1'b1, 1'b0, 1'b0);
        wait_cycles(20);
        exq.delete(); add_exp(1, 6); add_exp(7, 5);
        expect_q(2, start, "t4_data");
        chk("t4_ok", 32'(st_ok[2]), 32'd2);
        chk("t4_drop", 32'(st_drop[2]), 32'd0);

        // Random valid gaps and random output ready over four frames, one bad
        do_reset();
        o_ready[0] = 1'b0;
        start = q0.size();
        done5 = 1'b0;
        fork
            begin
                send_frame(0, 51, 3, 1'b0, 1'b1);
                send_frame(0, 61, 4, 1'b1, 1'b1);
                send_frame(0, 71, 5, 1'b0, 1'b1);
                send_frame(0, 81, 2, 1'b0, 1'b1);
                done5 = 1'b1;
            end
            begin
                while (!done5) begin
                    o_ready[0] = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        o_ready[0] = 1'b1;
        wait_cycles(30);
        exq.delete(); add_exp(51, 3); add_exp(71, 5); add_exp(81, 2);
        expect_q(0, start, "t5_data");
        chk("t5_ok", 32'(st_ok[0]), 32'd3);
        chk("t5_drop", 32'(st_drop[0]), 32'd1);

        // Reset in the middle of an input frame and of a readout
        do_reset();
        o_ready[0] = 1'b0;
        send_frame(0, 121, 5, 1'b0, 1'b0);
        send_beat(0, 8'd130, 1'b0, 1'b0, 1'b0);
        send_beat(0, 8'd131, 1'b0, 1'b0, 1'b0);
        o_ready[0] = 1'b1;
        wait_cycles(2);
        chk("t6_mid_valid", 32'(o_valid[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(o_valid[0]), 32'd0);
        chk("t6_rst_ok", 32'(st_ok[0]), 32'd0);
        chk("t6_rst_drop", 32'(st_drop[0]), 32'd0);
        chk("t6_rst_iready", 32'(i_ready[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        start = q0.size();
        send_frame(0, 141, 3, 1'b0, 1'b0);
        wait_cycles(10);
        exq.delete(); add_exp(141, 3);
        expect_q(0, start, "t6_data");
        chk("t6_ok", 32'(st_ok[0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
